// File: rtl/ok_btpipe_out_buffer.sv
// Block-throttled pipe-out buffer: serialises user words into 16-bit host words.
// Define OK_BTPIPE_STATUS_EN to enable the registered status word.
module ok_btpipe_out_buffer #(
  parameter int IN_WIDTH    = 32,
  parameter int DEPTH_LOG2  = 9,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                  ti_clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [IN_WIDTH-1:0]   din,
  input  logic                  din_wr,
  output logic                  full,
  input  logic                  ep_read,
  input  logic                  ep_blockstrobe,
  output logic [15:0]           ep_datain,
  output logic                  ep_ready,
  output logic [DEPTH_LOG2+2:0] level,
  output logic                  overflow,
  output logic                  underflow,
  output logic [15:0]           status
);

  localparam int K  = IN_WIDTH / 16;
  localparam int SW = (K > 1) ? $clog2(K) : 1;
  localparam int DW = DEPTH_LOG2 + 1;
  localparam int LW = DEPTH_LOG2 + 3;
  localparam int RW = $clog2(BLOCK_WORDS + 1);

  typedef enum logic {IDLE, BLOCK} state_t;

  state_t                 state;
  logic [RW-1:0]          remain;
  logic [DW-1:0]          wptr, rptr, wptr_n, rptr_n;
  logic [DW-1:0]          ent, ent_n;
  logic [SW-1:0]          sub, sub_n;
  logic [LW-1:0]          level_n;
  logic [IN_WIDTH-1:0]    mem [2**DEPTH_LOG2];
  logic [K-1:0][15:0]     head_w;
  logic                   empty, sub_last;
  logic                   push, pop, free;
  logic                   blk_n;

  assign ent      = wptr - rptr;
  assign empty    = (ent == '0);
  assign full     = ent[DEPTH_LOG2];
  assign sub_last = (sub == SW'(K - 1));
  assign push     = din_wr & ~full;
  assign pop      = ep_read & ~empty;
  assign free     = pop & sub_last;

  assign head_w    = mem[rptr[DEPTH_LOG2-1:0]];
  assign ep_datain = empty ? 16'h0 : head_w[sub];
  assign level     = LW'(K) * LW'(ent) - LW'(sub);

  always_comb begin
    wptr_n = wptr + DW'(push);
    rptr_n = rptr + DW'(free);
    sub_n  = sub;
    if (pop) sub_n = sub_last ? '0 : sub + SW'(1);
    ent_n   = wptr_n - rptr_n;
    level_n = LW'(K) * LW'(ent_n) - LW'(sub_n);
  end

  // Block state after this edge; ep_ready and status follow it.
  always_comb begin
    if (state == IDLE) blk_n = ep_blockstrobe;
    else               blk_n = !(pop && remain == RW'(1));
  end

  always_ff @(posedge ti_clk) begin
    if (push && !flush) mem[wptr[DEPTH_LOG2-1:0]] <= din;
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      sub       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      sub       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr_n;
      rptr      <= rptr_n;
      sub       <= sub_n;
      overflow  <= overflow | (din_wr & full);
      underflow <= underflow | (ep_read & empty);
    end
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      remain   <= '0;
      ep_ready <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      remain   <= '0;
      ep_ready <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ep_blockstrobe) begin
            state  <= BLOCK;
            remain <= RW'(BLOCK_WORDS);
          end
        end
        BLOCK: begin
          if (pop) begin
            remain <= remain - RW'(1);
            if (remain == RW'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      ep_ready <= !blk_n && (level_n >= LW'(BLOCK_WORDS));
    end
  end

`ifdef OK_BTPIPE_STATUS_EN
  logic [11:0] lvl_sat;
  logic        ovf_n, udf_n;

  assign lvl_sat = (int'(level_n) > 4095) ? 12'hFFF : 12'(level_n);
  assign ovf_n   = overflow | (din_wr & full);
  assign udf_n   = underflow | (ep_read & empty);

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n)     status <= '0;
    else if (flush) status <= '0;
    else status <= {ovf_n, udf_n, blk_n, ent_n[DEPTH_LOG2], lvl_sat};
  end
`else
  assign status = '0;
`endif

endmodule

// File: tb/tb_ok_btpipe_out_buffer.sv
// Randomised + directed bench for ok_btpipe_out_buffer against a host-word queue model.
module tb_ok_btpipe_out_buffer;

  localparam int IW = 32;
  localparam int DL = 9;
  localparam int BW = 8;
  localparam int K  = IW / 16;
  localparam int SLOTS = 2 ** DL;

  logic          ti_clk, rst_n, flush;
  logic [IW-1:0] din;
  logic          din_wr, full, ep_read, ep_blockstrobe;
  logic [15:0]   ep_datain, status;
  logic          ep_ready, overflow, underflow;
  logic [DL+2:0] level;

  ok_btpipe_out_buffer #(
    .IN_WIDTH(IW), .DEPTH_LOG2(DL), .BLOCK_WORDS(BW)
  ) dut (
    .ti_clk(ti_clk), .rst_n(rst_n), .flush(flush),
    .din(din), .din_wr(din_wr), .full(full),
    .ep_read(ep_read), .ep_blockstrobe(ep_blockstrobe),
    .ep_datain(ep_datain), .ep_ready(ep_ready), .level(level),
    .overflow(overflow), .underflow(underflow), .status(status)
  );

  initial ti_clk = 1'b0;
  always #5 ti_clk = ~ti_clk;

  // Reference model: a queue of 16-bit host words.
  logic [15:0] q[$];
  bit  m_ovf, m_udf, m_blk;
  int  m_rem;
  bit  m_rdy;
  int  total, passed;

  function automatic bit m_full();
    return ((q.size() + K - 1) / K) == SLOTS;
  endfunction

  task automatic m_clear();
    q.delete();
    m_ovf = 0; m_udf = 0; m_blk = 0; m_rem = 0; m_rdy = 0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [15:0] exp_st;
    int lv;
    lv = q.size();
    exp_st = 16'h0;
`ifdef OK_BTPIPE_STATUS_EN
    exp_st = {m_ovf, m_udf, m_blk, m_full(),
              (lv > 4095) ? 12'hFFF : 12'(lv)};
`endif
    chk("level", 32'(level), 32'(lv));
    chk("ep_datain", 32'(ep_datain), (lv > 0) ? 32'(q[0]) : 32'h0);
    chk("full", 32'(full), 32'(m_full()));
    chk("ep_ready", 32'(ep_ready), 32'(m_rdy));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("status", 32'(status), 32'(exp_st));
  endtask

  task automatic step(bit wr, logic [IW-1:0] d, bit rd, bit bs, bit fl);
    bit fullp, emp, popd;
    din_wr = wr; din = d; ep_read = rd;
    ep_blockstrobe = bs; flush = fl;
    @(posedge ti_clk);
    if (fl) m_clear();
    else begin
      fullp = m_full();
      emp   = (q.size() == 0);
      if (rd && emp) m_udf = 1;
      if (wr && fullp) m_ovf = 1;
      popd = rd && !emp;
      if (popd) void'(q.pop_front());
      if (wr && !fullp)
        for (int k = 0; k < K; k++) q.push_back(d[16*k +: 16]);
      if (!m_blk) begin
        if (bs) begin m_blk = 1; m_rem = BW; end
      end else if (popd) begin
        if (m_rem == 1) m_blk = 0;
        else m_rem--;
      end
      m_rdy = !m_blk && (q.size() >= BW);
    end
    #1;
    din_wr = 0; ep_read = 0; ep_blockstrobe = 0; flush = 0;
    check_all();
  endtask

  initial begin
    total = 0; passed = 0;
    m_clear();
    rst_n = 0; flush = 0; din = '0; din_wr = 0;
    ep_read = 0; ep_blockstrobe = 0;
    #12;
    check_all();
    #1 rst_n = 1;

    // First block: 4 words = 8 host words
    step(1, 32'hBBBBAAAA, 0, 0, 0);
    chk("first_head", 32'(ep_datain), 32'h0000AAAA);
    for (int i = 0; i < 3; i++) step(1, $urandom(), 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    chk("second_half", 32'(ep_datain), 32'h0000BBBB);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
    chk("block_done_level", 32'(level), 32'h0);

    // Underflow on empty
    step(0, 0, 1, 0, 0);
    chk("udf_flag", 32'(underflow), 32'h1);

    // Simultaneous push and sub=1 pop at level 3
    step(0, 0, 0, 0, 1);
    step(1, $urandom(), 0, 0, 0);
    step(1, $urandom(), 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, $urandom(), 1, 0, 0);
    chk("push_pop_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);

    // Fill to full, then overflow
    for (int i = 0; i < SLOTS; i++) step(1, $urandom(), 0, 0, 0);
    chk("full_set", 32'(full), 32'h1);
    step(1, $urandom(), 0, 0, 0);
    chk("ovf_level", 32'(level), 32'd1024);
    step(0, 0, 0, 0, 1);

    // Async reset mid-block after 3 of 8 reads
    for (int i = 0; i < 4; i++) step(1, $urandom(), 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    rst_n = 0;
    #2;
    m_clear();
    check_all();
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) step(1, $urandom(), 0, 0, 0);
    chk("ready_after_rst", 32'(ep_ready), 32'h1);

    // Randomised traffic, two biases
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        step($urandom_range(0, 99) < (ph == 0 ? 60 : 40), $urandom(),
             $urandom_range(0, 99) < (ph == 0 ? 40 : 60),
             $urandom_range(0, 99) < 8,
             $urandom_range(0, 499) == 0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
